bram_port_arbiter: RTL

- Shares one BRAM port (32-bit data, byte write enables) between NUM_REQ requesters, e.g. pe_con and a host/DMA loader.
- Arbitration is round-robin, with an optional per-requester lock for bursts.
- Routes read data back to the issuing requester after a fixed read latency.
- Sits between the requesters and my_bram; drives BRAM_CLK from aclk.

---
 rtl/bram_arb_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 82 ++++++++
 rtl/bram_port_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/bram_arb_pkg.sv
// Shared constants, types and the round-robin pick function for the BRAM port arbiter.
package bram_arb_pkg;

    localparam int BRAM_DATA_W = 32;
    localparam int BRAM_WE_W   = 4;
    localparam int MAX_REQ     = 4;
    localparam int STAT_W      = 16;
    localparam int IDX_W       = 2;

    typedef logic [MAX_REQ-1:0] req_vec_t;
    typedef logic [IDX_W-1:0]   req_idx_t;

    typedef struct packed {
        logic     valid;
        req_idx_t owner;
    } lock_t;

    // First asserted request at or after ptr, wrapping modulo n; returns one-hot.
    function automatic req_vec_t rr_pick(input req_vec_t req_v, input req_idx_t ptr, input int n);
        req_vec_t onehot;
        req_idx_t idx;
        onehot = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = req_idx_t'((int'(ptr) + k) % n);
            if (k < n && onehot == '0 && req_v[idx]) begin
                onehot[idx] = 1'b1;
            end
        end
        return onehot;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with per-requester burst lock; owns the pointer and lock-owner state.
module rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_lock,
    output logic [NUM_REQ-1:0] o_gnt
);

    req_idx_t r_ptr;
    req_idx_t w_ptr_nxt;
    lock_t    r_lock;
    lock_t    w_lock_nxt;
    req_vec_t w_req_ext;
    req_vec_t w_lock_ext;
    req_vec_t w_pick;
    req_idx_t w_win;
    logic     w_any;

    function automatic req_idx_t next_idx(input req_idx_t idx);
        return req_idx_t'((int'(idx) + 1) % NUM_REQ);
    endfunction

    assign w_req_ext  = req_vec_t'(i_req);
    assign w_lock_ext = req_vec_t'(i_lock);

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_ptr  <= '0;
            r_lock <= '0;
        end else begin
            r_ptr  <= w_ptr_nxt;
            r_lock <= w_lock_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_ptr_nxt  = r_ptr;
        w_lock_nxt = r_lock;
        if (r_lock.valid) begin
            if (!w_lock_ext[r_lock.owner]) begin
                w_lock_nxt = '0;
                w_ptr_nxt  = next_idx(r_lock.owner);
            end
        end else if (w_any) begin
            if (w_lock_ext[w_win]) begin
                w_lock_nxt = '{valid: 1'b1, owner: w_win};
            end else begin
                w_ptr_nxt = next_idx(w_win);
            end
        end
    end

    // While locked only the owner may win, and the port idles if it is not requesting.
    always_comb begin
        w_pick = '0;
        if (r_lock.valid) begin
            w_pick[r_lock.owner] = w_req_ext[r_lock.owner];
        end else begin
            w_pick = rr_pick(w_req_ext, r_ptr, NUM_REQ);
        end
    end

    always_comb begin
        w_win = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (w_pick[i]) begin
                w_win = req_idx_t'(i);
            end
        end
    end

    assign w_any = |w_pick;
    assign o_gnt = w_pick[NUM_REQ-1:0];

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between NUM_REQ requesters and returns read data to the issuer.
// Define BRAM_ARB_STATS_EN to add per-requester saturating grant counters (grant_cnt, stats_clr).
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             lock,
    input  logic [BRAM_WE_W*NUM_REQ-1:0]   we,
    input  logic [ADDR_WIDTH*NUM_REQ-1:0]  addr,
    input  logic [BRAM_DATA_W*NUM_REQ-1:0] wrdata,
`ifdef BRAM_ARB_STATS_EN
    input  logic                           stats_clr,
    output logic [STAT_W*NUM_REQ-1:0]      grant_cnt,
`endif
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             rdvalid,
    output logic [BRAM_DATA_W-1:0]         rddata,
    output logic                           BRAM_CLK,
    output logic                           BRAM_EN,
    output logic [BRAM_WE_W-1:0]           BRAM_WE,
    output logic [ADDR_WIDTH-1:0]          BRAM_ADDR,
    output logic [BRAM_DATA_W-1:0]         BRAM_WRDATA,
    input  logic [BRAM_DATA_W-1:0]         BRAM_RDDATA
);

    logic [NUM_REQ-1:0]     w_gnt;
    logic [NUM_REQ-1:0]     w_rd_issue;
    logic [NUM_REQ-1:0]     w_rd_tail;
    logic [NUM_REQ-1:0]     r_rdvalid;
    logic [BRAM_DATA_W-1:0] r_rddata;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .aclk   (aclk),
        .areset (areset),
        .i_req  (req),
        .i_lock (lock),
        .o_gnt  (w_gnt)
    );

    always_comb begin
        BRAM_WE     = '0;
        BRAM_ADDR   = '0;
        BRAM_WRDATA = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                BRAM_WE     = we[i*BRAM_WE_W +: BRAM_WE_W];
                BRAM_ADDR   = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                BRAM_WRDATA = wrdata[i*BRAM_DATA_W +: BRAM_DATA_W];
            end
        end
    end

    assign BRAM_CLK   = aclk;
    assign BRAM_EN    = |w_gnt;
    assign gnt        = w_gnt;
    assign w_rd_issue = (BRAM_WE == '0) ? w_gnt : '0;

    // The output register is the last stage; earlier stages only carry the one-hot tag.
    if (RD_LATENCY > 1) begin : g_tag_pipe
        logic [NUM_REQ-1:0] r_tag [RD_LATENCY-1];

        // NOTE: the tag stages are reset so reads in flight at reset never report rdvalid.
        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                for (int k = 0; k < RD_LATENCY-1; k++) begin
                    r_tag[k] <= '0;
                end
            end else begin
                r_tag[0] <= w_rd_issue;
                for (int k = 1; k < RD_LATENCY-1; k++) begin
                    r_tag[k] <= r_tag[k-1];
                end
            end
        end

        assign w_rd_tail = r_tag[RD_LATENCY-2];
    end else begin : g_tag_direct
        assign w_rd_tail = w_rd_issue;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rdvalid <= '0;
            r_rddata  <= '0;
        end else begin
            r_rdvalid <= w_rd_tail;
            if (|w_rd_tail) begin
                r_rddata <= BRAM_RDDATA;
            end
        end
    end

    assign rdvalid = r_rdvalid;
    assign rddata  = r_rddata;

`ifdef BRAM_ARB_STATS_EN
    logic [STAT_W-1:0] r_cnt [NUM_REQ];

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (stats_clr) begin
                    r_cnt[i] <= '0;
                end else if (w_gnt[i] && r_cnt[i] != '1) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
        assign grant_cnt[g*STAT_W +: STAT_W] = r_cnt[g];
    end
`endif

endmodule
